fmap_stream_reader: RTL and testbench
=====================================

// Module: fmap_stream_reader
// PURPOSE
//  Reads a stored feature map (C channels of W x W words) from a 1-cycle-latency RAM and streams it
//  to the next convolution block. Channel-major, raster order inside each channel.
//  Counterpart of the conv-block writer: previous block fills the RAM, this block replays it downstream.
// PARAMETERS
//  DATA_WIDTH         32   pixel word width (fp32)
//  IMAGE_WIDTH        56   W, feature-map side length
//  NUMBER_OF_CHANNEL  8    C, channels to stream
//  ADDR_WIDTH         15   RAM address width, must satisfy 2^ADDR_WIDTH >= W*W*C
//  BASE_ADDR          0    RAM address of pixel (ch0,row0,col0)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-high
//  i_valid       in   1           start pulse; sampled only in IDLE
//  o_mem_rd_en   out  1           RAM read strobe
//  o_mem_addr    out  ADDR_WIDTH  RAM read address
//  i_mem_data    in   DATA_WIDTH  RAM read data, valid 1 cycle after o_mem_rd_en
//  o_data        out  DATA_WIDTH  stream pixel
//  o_data_valid  out  1           stream valid
//  i_data_ready  in   1           stream ready; transfer when valid && ready
//  o_channel     out  $clog2(C)   channel index of o_data (min width 1)
//  o_last_pixel  out  1           o_data is last pixel of current channel
//  o_valid       out  1           one-cycle done pulse after final transfer
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0, o_mem_rd_en/o_data_valid/o_last_pixel/o_valid=0,
//    o_data=0, o_mem_addr=BASE_ADDR, o_channel=0, FIFO emptied.
//  - FSM: IDLE -(i_valid)-> RUN -(last read issued)-> DRAIN -(FIFO empty, last transfer)-> DONE -> IDLE.
//    DONE lasts exactly one cycle and drives o_valid=1. i_valid outside IDLE ignored.
//  - RUN: issue read when FIFO occupancy + reads in flight < 2 (credit count), so no pixel is ever lost
//    under back-pressure. Address = BASE_ADDR + ch*W*W + row*W + col, increments by 1 per read.
//  - Returned data enters 2-entry FIFO; head drives o_data/o_data_valid. Valid never drops without a
//    transfer; o_data/o_channel/o_last_pixel stable while valid && !ready.
//  - Latency: first o_data_valid 2 cycles after i_valid sampled (read issue, RAM return).
//    Full throughput 1 pixel/cycle with ready held high; done pulse the cycle after final transfer.
//  - Sideband (channel, last flag) travels with each read through the FIFO, not recomputed at output.
//  - Counters: col wraps W-1->0 incrementing row; row wraps W-1->0 incrementing ch; ch==C-1 && row/col
//    final -> last read, enter DRAIN.
//  - Total transfers exactly W*W*C (padding off). Reset mid-operation: immediate IDLE, no done pulse,
//    pending RAM data discarded.
// CONFIGURATION
//  FMAP_ZERO_PAD_EN defined: stream is (W+2)x(W+2) per channel with 1-pixel zero border for 3x3 same
//    convolution; border pixels injected as 0 without RAM read (still through FIFO, credit-counted);
//    interior addresses unchanged; total transfers (W+2)^2*C; o_last_pixel on pad pixel (W+1,W+1).
//  Undefined: no padding, W*W*C transfers, every pixel from RAM.
// STRUCTURE
//  - Shared package fmap_pkg: FSM state encoding (IDLE,RUN,DRAIN,DONE), localparams PIX_PER_CH and
//    TOTAL_PIX derived from W/C (padding-aware), channel-width function.
//  - Sub-module fmap_skid_fifo: 2-entry FIFO, data+channel+last payload, push/pop/full/empty/count.
//  - Top: FSM, row/col/ch counters, address generator, credit counter, pad injection (optional).
// TESTING  (W=4, C=2, BASE_ADDR=0, RAM word at addr a = a)
//  1 ready=1, pulse i_valid -> 32 transfers, data 0..31, o_channel 0 for 0..15 / 1 for 16..31,
//    o_last_pixel on 15 and 31, o_valid 1 cycle after data 31, exactly once.
//  2 ready toggled 1-0-1-0 / random 30% low -> same 32-value sequence, no drop/duplication,
//    outputs stable during stall, rd_en never issued with 2 credits outstanding.
//  3 i_valid pulsed again during RUN -> ignored, sequence unchanged; pulse after o_valid -> full replay.
//  4 rst asserted after 10th transfer -> all outputs 0 next edge, no o_valid; new start gives 0..31.
//  5 BASE_ADDR=100 -> addresses 100..131, data 100..131.
//  6 FMAP_ZERO_PAD_EN -> 72 transfers; channel 0 row0 = 0x6, row1 = 0,0,1,2,3,0; last flag at 35 and 71.

Source files
------------

// File: rtl/fmap_pkg.sv
// ============================================================================
// Module      : fmap_pkg
// Description : Shared FSM encoding and geometry helpers for the feature-map
//               stream reader. Honours FMAP_ZERO_PAD_EN (1-pixel zero border).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmap_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int ch_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Side length of the streamed square, border included when padding is on.
  function automatic int side_len(input int w);
`ifdef FMAP_ZERO_PAD_EN
    return w + 2;
`else
    return w;
`endif
  endfunction

  function automatic int pix_per_ch(input int w);
    return side_len(w) * side_len(w);
  endfunction

  function automatic int total_pix(input int w, input int c);
    return pix_per_ch(w) * c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fmap_skid_fifo.sv
// ============================================================================
// Module      : fmap_skid_fifo
// Description : 2-entry FIFO carrying pixel data plus channel/last sideband.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_skid_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] r_mem;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == 2'd2);
  assign empty    = (r_count == 2'd0);
  assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/fmap_stream_reader.sv
// ============================================================================
// Module      : fmap_stream_reader
// Description : Replays a C x W x W feature map from 1-cycle RAM as a
//               ready/valid stream. Optional zero border: FMAP_ZERO_PAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_stream_reader
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int IMAGE_WIDTH       = 56,
  parameter int NUMBER_OF_CHANNEL = 8,
  parameter int ADDR_WIDTH        = 15,
  parameter int BASE_ADDR         = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  output logic                                 o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  input  logic [DATA_WIDTH-1:0]                i_mem_data,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic                                 o_data_valid,
  input  logic                                 i_data_ready,
  output logic [ch_width(NUMBER_OF_CHANNEL)-1:0] o_channel,
  output logic                                 o_last_pixel,
  output logic                                 o_valid
);

  localparam int CH_W  = ch_width(NUMBER_OF_CHANNEL);
  localparam int DIM   = side_len(IMAGE_WIDTH);
  localparam int CNT_W = cnt_width(DIM);
  localparam int PW    = DATA_WIDTH + CH_W + 1;
  localparam logic [CNT_W-1:0]      LAST_POS = CNT_W'(DIM - 1);
  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUMBER_OF_CHANNEL - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_run;
  logic [CNT_W-1:0]      r_col;
  logic [CNT_W-1:0]      r_row;
  logic [CH_W-1:0]       r_ch;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic                  r_inflight_pad;
  logic [CH_W-1:0]       r_inflight_ch;
  logic                  r_inflight_last;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [1:0]            w_fifo_count;
  logic [PW-1:0]         w_fifo_head;
  logic [PW-1:0]         w_push_data;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_at_last_pos;
  logic                  w_last_read;
  logic                  w_is_pad;
  logic                  w_start;

  assign w_start = (r_state == ST_IDLE) && i_valid;
  assign w_pop   = !w_fifo_empty && i_data_ready;

  // Credits: a slot is free once FIFO entries plus the read in flight, less
  // this cycle's pop, drop below two - keeps full rate with ready held high.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_issue = w_run && (w_occ < (3'd2 + {2'b00, w_pop})) && !(w_fifo_full && !w_pop);

  assign w_at_last_pos = (r_row == LAST_POS) && (r_col == LAST_POS);
  assign w_last_read   = w_issue && w_at_last_pos && (r_ch == LAST_CH);

`ifdef FMAP_ZERO_PAD_EN
  assign w_is_pad = (r_row == '0) || (r_row == LAST_POS) || (r_col == '0) || (r_col == LAST_POS);
`else
  assign w_is_pad = 1'b0;
`endif

  assign o_mem_rd_en = w_issue && !w_is_pad;
  assign o_mem_addr  = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_valid) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last_read) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && (w_fifo_count == 2'd1) && !r_inflight) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run   = (r_state == ST_RUN);
    o_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_ch   <= '0;
      r_addr <= BASE;
    end else if (w_start) begin
      r_col  <= '0;
      r_row  <= '0;
      r_ch   <= '0;
      r_addr <= BASE;
    end else if (w_issue) begin
      if (r_col == LAST_POS) begin
        r_col <= '0;
        if (r_row == LAST_POS) begin
          r_row <= '0;
          r_ch  <= r_ch + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
      // Border pixels never touch RAM, so interior addresses stay contiguous.
      if (!w_is_pad) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_pad  <= 1'b0;
      r_inflight_ch   <= '0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_pad  <= w_is_pad;
      r_inflight_ch   <= r_ch;
      r_inflight_last <= w_at_last_pos;
    end
  end

  assign w_push_data = {(r_inflight_pad ? {DATA_WIDTH{1'b0}} : i_mem_data),
                        r_inflight_ch, r_inflight_last};

  fmap_skid_fifo #(
    .WIDTH (PW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign o_data_valid = !w_fifo_empty;
  assign {o_data, o_channel, o_last_pixel} = w_fifo_head;

endmodule

`default_nettype wire

// File: tb/tb_fmap_stream_reader.sv
// ============================================================================
// Module      : tb_fmap_stream_reader
// Description : Randomized self-checking bench for fmap_stream_reader
//               (W=4, C=2); follows FMAP_ZERO_PAD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmap_stream_reader;

  localparam int W  = 4;
  localparam int C  = 2;
  localparam int AW = 15;
`ifdef FMAP_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int DIM   = W + 2 * PAD;
  localparam int PPC   = DIM * DIM;
  localparam int TOTAL = PPC * C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_data_ready = 1'b1;
  logic          o_mem_rd_en;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   i_mem_data = '0;
  logic [31:0]   o_data;
  logic          o_data_valid;
  logic [0:0]    o_channel;
  logic          o_last_pixel;
  logic          o_valid;

  logic          b_valid = 1'b0;
  logic          b_rd_en;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_mem_data = '0;
  logic [31:0]   b_data;
  logic          b_data_valid;
  logic [0:0]    b_channel;
  logic          b_last;
  logic          b_done;

  int n_tests = 0;
  int n_fail  = 0;
  int idx = 0, done_cnt = 0, rd_total = 0, xfer_total = 0;
  int idx_b = 0, done_b = 0, addr_k = 0;
  bit prev_final = 0, prev_stall = 0;
  logic [31:0] prev_data;
  logic [0:0]  prev_ch;
  logic        prev_last;

  always #5 clk = ~clk;

  fmap_stream_reader #(.DATA_WIDTH(32), .IMAGE_WIDTH(W), .NUMBER_OF_CHANNEL(C),
                       .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_mem_rd_en(o_mem_rd_en),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_data(o_data),
    .o_data_valid(o_data_valid), .i_data_ready(i_data_ready), .o_channel(o_channel),
    .o_last_pixel(o_last_pixel), .o_valid(o_valid));

  fmap_stream_reader #(.DATA_WIDTH(32), .IMAGE_WIDTH(W), .NUMBER_OF_CHANNEL(C),
                       .ADDR_WIDTH(AW), .BASE_ADDR(100)) dut_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .o_mem_rd_en(b_rd_en),
    .o_mem_addr(b_addr), .i_mem_data(b_mem_data), .o_data(b_data),
    .o_data_valid(b_data_valid), .i_data_ready(1'b1), .o_channel(b_channel),
    .o_last_pixel(b_last), .o_valid(b_done));

  // RAM model: word at address a holds a, one-cycle read latency.
  always @(posedge clk) begin
    if (o_mem_rd_en) i_mem_data <= 32'(o_mem_addr);
    if (b_rd_en)     b_mem_data <= 32'(b_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: k-th streamed pixel in channel-major raster order.
  function automatic logic [31:0] exp_pix(input int base, input int k);
    int ch = k / PPC;
    int r  = (k % PPC) / DIM;
    int c  = k % DIM;
    if (PAD != 0 && (r == 0 || r == DIM - 1 || c == 0 || c == DIM - 1)) return 32'd0;
    return 32'(base + ch * W * W + (r - PAD) * W + (c - PAD));
  endfunction

  function automatic logic [31:0] exp_ch(input int k);
    return 32'(k / PPC);
  endfunction

  function automatic logic [31:0] exp_last(input int k);
    return 32'((k % PPC) == PPC - 1);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_final = 0; prev_stall = 0; rd_total = 0; xfer_total = 0;
    end else begin
      check("done_timing", 32'(o_valid), 32'(prev_final));
      if (o_valid) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", 32'(o_data_valid), 32'd1);
        check("stall_data", o_data, prev_data);
        check("stall_ch", 32'(o_channel), 32'(prev_ch));
        check("stall_last", 32'(o_last_pixel), 32'(prev_last));
      end
      prev_final = 0;
      if (o_mem_rd_en) rd_total++;
      if (o_data_valid && i_data_ready) begin
        if (idx < TOTAL) begin
          check("data", o_data, exp_pix(0, idx));
          check("channel", 32'(o_channel), exp_ch(idx));
          check("last", 32'(o_last_pixel), exp_last(idx));
        end else begin
          check("extra_xfer", 32'(idx), 32'(TOTAL - 1));
        end
        xfer_total++;
        idx++;
        prev_final = (idx == TOTAL);
      end
`ifndef FMAP_ZERO_PAD_EN
      check("credit", 32'((rd_total - xfer_total) <= 2), 32'd1);
`endif
      prev_stall = o_data_valid && !i_data_ready;
      prev_data  = o_data;
      prev_ch    = o_channel;
      prev_last  = o_last_pixel;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_done) done_b++;
      if (b_rd_en) begin
        check("b_addr", 32'(b_addr), 32'(100 + addr_k));
        addr_k++;
      end
      if (b_data_valid) begin
        check("b_data", b_data, exp_pix(100, idx_b));
        idx_b++;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
  endtask

  task automatic run(input int mode, input bit mid, input bit lat);
    bit pulsed = 0;
    idx = 0; done_cnt = 0;
    i_data_ready = 1'b1;
    pulse_start();
    if (lat) begin
      @(negedge clk); check("lat_cyc0", 32'(o_data_valid), 32'd0);
      @(negedge clk); check("lat_cyc1", 32'(o_data_valid), 32'd0);
      @(negedge clk); check("lat_cyc2", 32'(o_data_valid), 32'd1);
    end
    for (int cyc = 0; cyc < 1000 && done_cnt == 0; cyc++) begin
      case (mode)
        1:       i_data_ready = (cyc % 2 == 0);
        2:       i_data_ready = ($urandom_range(0, 99) >= 30);
        default: i_data_ready = 1'b1;
      endcase
      if (mid && !pulsed && idx >= 5) begin
        i_valid = 1'b1; pulsed = 1;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("xfer_count", 32'(idx), 32'(TOTAL));
    check("done_once", 32'(done_cnt), 32'd1);
  endtask

  task automatic reset_mid_run();
    idx = 0; done_cnt = 0;
    pulse_start();
    for (int cyc = 0; cyc < 1000 && idx < 10; cyc++) begin
      i_data_ready = ($urandom_range(0, 99) >= 30);
      @(posedge clk); #1;
    end
    check("rst_at_idx", 32'(idx), 32'd10);
    rst = 1'b1;
    #1;
    check("rst_rd_en", 32'(o_mem_rd_en), 32'd0);
    check("rst_addr", 32'(o_mem_addr), 32'd0);
    check("rst_dvalid", 32'(o_data_valid), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_ch", 32'(o_channel), 32'd0);
    check("rst_last", 32'(o_last_pixel), 32'd0);
    check("rst_done", 32'(o_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; i_data_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_idle_dvalid", 32'(o_data_valid), 32'd0);
  endtask

  task automatic run_b();
    idx_b = 0; done_b = 0; addr_k = 0;
    @(posedge clk); #1 b_valid = 1'b1;
    @(posedge clk); #1 b_valid = 1'b0;
    for (int cyc = 0; cyc < 500 && done_b == 0; cyc++) begin
      @(posedge clk); #1;
    end
    check("b_xfers", 32'(idx_b), 32'(TOTAL));
    check("b_reads", 32'(addr_k), 32'(W * W * C));
    check("b_done", 32'(done_b), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("init_dvalid", 32'(o_data_valid), 32'd0);
    check("init_addr", 32'(o_mem_addr), 32'd0);
    check("init_done", 32'(o_valid), 32'd0);
    rst = 1'b0;
    run(0, 0, 1);
    run(0, 0, 0);
    run(1, 0, 0);
    run(2, 0, 0);
    run(2, 1, 0);
    reset_mid_run();
    run(0, 0, 0);
    run_b();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
